// File: rtl/reg_write_scoreboard_pkg.sv
// Shared definitions for the register-write scoreboard: forward-select
// encodings, the in-flight slot record and small slot helpers.
package reg_write_scoreboard_pkg;

   localparam int unsigned SB_REG_AW = 5;
   localparam int unsigned SB_NREG   = 32;

   // Forward-select encodings seen by the ID-stage operand muxes.
   // 2'b11 is reserved and never produced.
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // One in-flight register write: valid, destination, produced-by-load.
   typedef struct packed {
      logic                 v;
      logic [SB_REG_AW-1:0] rnum;
      logic                 ld;
   } slot_t;

   localparam slot_t SLOT_EMPTY = slot_t'({(SB_REG_AW + 2){1'b0}});

   // True when the slot holds a live write to register r.
   function automatic logic slot_hit(input slot_t s, input logic [SB_REG_AW-1:0] r);
      return s.v && (s.rnum == r);
   endfunction

   // Number of live slots among EX, MEM, WB (0..3 fits in two bits).
   function automatic logic [1:0] count_valid(input slot_t s_ex, input slot_t s_mem,
                                              input slot_t s_wb);
      return {1'b0, s_ex.v} + {1'b0, s_mem.v} + {1'b0, s_wb.v};
   endfunction

endpackage

// File: rtl/reg_write_scoreboard_sb_query_port.sv
// One operand query against the three in-flight slots. Produces the
// forward select and stall request for a single ID-stage source register.
module sb_query_port
   import reg_write_scoreboard_pkg::*;
(
   input  slot_t                ex_slot_i,
   input  slot_t                mem_slot_i,
   input  slot_t                wb_slot_i,
   input  logic                 q_use_id_i,
   input  logic [SB_REG_AW-1:0] q_reg_i,
   output logic [1:0]           fwd_o,
   output logic                 stall_o
);

   logic       hit_ex_s;
   logic       hit_mem_s;
   logic       hit_wb_s;
   logic [1:0] fwd_s;
   logic       stall_s;

   assign hit_ex_s  = slot_hit(ex_slot_i,  q_reg_i);
   assign hit_mem_s = slot_hit(mem_slot_i, q_reg_i);
   assign hit_wb_s  = slot_hit(wb_slot_i,  q_reg_i);

   // Youngest matching slot decides; $0 never forwards or stalls, and a
   // stalled operand always reports the regfile select.
   always_comb begin
      fwd_s   = FWD_RF;
      stall_s = 1'b0;
      if (q_reg_i == {SB_REG_AW{1'b0}}) begin
         fwd_s   = FWD_RF;
         stall_s = 1'b0;
      end else if (q_use_id_i) begin
         // Operand is needed in ID: EX result is not ready yet, and a load
         // in MEM has not returned its data.
         if (hit_ex_s) begin
            stall_s = 1'b1;
         end else if (hit_mem_s) begin
            if (mem_slot_i.ld) begin
               stall_s = 1'b1;
            end else begin
               fwd_s = FWD_EXMEM;
            end
         end else if (hit_wb_s) begin
            fwd_s = FWD_MEMWB;
         end else begin
            fwd_s = FWD_RF;
         end
      end else begin
         // Operand is consumed in EX: only the load-use case stalls here;
         // EX-stage forwarding is decided by the EX forwarding unit.
         if (hit_ex_s && ex_slot_i.ld) begin
            stall_s = 1'b1;
         end else begin
            stall_s = 1'b0;
         end
         fwd_s = FWD_RF;
      end
   end

   assign fwd_o   = fwd_s;
   assign stall_o = stall_s;

endmodule

// File: rtl/reg_write_scoreboard.sv
// Producer side of the ID-stage hazard/forwarding interface. Tracks every
// register write from the moment it leaves ID until it retires at WB and
// answers rs/rt queries with forward selects and a stall request.
module reg_write_scoreboard
   import reg_write_scoreboard_pkg::*;
#(
   parameter int unsigned REG_AW = SB_REG_AW,
   parameter int unsigned NREG   = SB_NREG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_stall,
   input  logic              id_issue,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_wr_reg,
   input  logic              id_is_load,
   input  logic              q_use_id,
   input  logic [REG_AW-1:0] q_rs,
   input  logic [REG_AW-1:0] q_rt,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              hazard_stall,
   output logic [NREG-1:0]   busy_vec,
   output logic [1:0]        inflight_cnt
);

   slot_t           ex_q,  ex_d;
   slot_t           mem_q, mem_d;
   slot_t           wb_q,  wb_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic [1:0]      cnt_q, cnt_d;

   logic            stall_a_s;
   logic            stall_b_s;
   logic            issue_ok_s;
   slot_t           new_ex_s;

   // Operand A (rs) query.
   sb_query_port u_query_rs (
      .ex_slot_i  (ex_q),
      .mem_slot_i (mem_q),
      .wb_slot_i  (wb_q),
      .q_use_id_i (q_use_id),
      .q_reg_i    (q_rs),
      .fwd_o      (fwd_a),
      .stall_o    (stall_a_s)
   );

   // Operand B (rt) query.
   sb_query_port u_query_rt (
      .ex_slot_i  (ex_q),
      .mem_slot_i (mem_q),
      .wb_slot_i  (wb_q),
      .q_use_id_i (q_use_id),
      .q_reg_i    (q_rt),
      .fwd_o      (fwd_b),
      .stall_o    (stall_b_s)
   );

   assign hazard_stall = stall_a_s | stall_b_s;

   // A write enters EX only when the instruction really advances and names
   // a register other than $0; a stalled ID becomes a bubble instead.
   assign issue_ok_s = id_issue & id_wr_en & (id_wr_reg != {REG_AW{1'b0}}) & ~hazard_stall;

   assign new_ex_s.v    = 1'b1;
   assign new_ex_s.rnum = id_wr_reg;
   assign new_ex_s.ld   = id_is_load;

   // Next-state slot shift: freeze everything on a memory stall, otherwise
   // advance one stage and load EX with the new write or a bubble.
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (mem_stall) begin
         ex_d  = ex_q;
         mem_d = mem_q;
         wb_d  = wb_q;
      end else begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (issue_ok_s) begin
            ex_d = new_ex_s;
         end else begin
            ex_d = SLOT_EMPTY;
         end
      end
   end

   // Busy map and live-slot count follow the next-state slots so they
   // change on the same edge as the slots; a register named twice stays
   // busy until its last slot retires.
   always_comb begin
      busy_d = {NREG{1'b0}};
      if (ex_d.v) begin
         busy_d[ex_d.rnum] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      if (mem_d.v) begin
         busy_d[mem_d.rnum] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      if (wb_d.v) begin
         busy_d[wb_d.rnum] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      cnt_d = count_valid(ex_d, mem_d, wb_d);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q   <= SLOT_EMPTY;
         mem_q  <= SLOT_EMPTY;
         wb_q   <= SLOT_EMPTY;
         busy_q <= {NREG{1'b0}};
         cnt_q  <= 2'd0;
      end else begin
         ex_q   <= ex_d;
         mem_q  <= mem_d;
         wb_q   <= wb_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_vec     = busy_q;
   assign inflight_cnt = cnt_q;

endmodule
